// File: rtl/dither_pkg.sv
// Shared types and helpers for the dither packing path.
// The packed word layout is shared with the BRAM writer.
package dither_pkg;

  localparam int DEF_FRAME_W = 320;
  localparam int DEF_FRAME_H = 240;
  localparam int PACK_AW     = 18;

  function automatic int words_per_row(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int addr_bits(input int w, input int h);
    int n;
    n = words_per_row(w) * h;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [PACK_AW-1:0] addr;
    logic [7:0]         data;
  } pack_word_t;

endpackage

// File: rtl/dither_packer_if.sv
// Packed-word valid/ready bus toward the frame writer.
// The master holds valid/data/addr until accepted.
interface dither_packer_if
  import dither_pkg::*;
#(
  parameter int ADDR_W = addr_bits(DEF_FRAME_W, DEF_FRAME_H)
) ();

  logic              word_valid;
  logic              word_ready;
  logic [7:0]        word_data;
  logic [ADDR_W-1:0] word_addr;

  modport master (
    output word_valid,
    output word_data,
    output word_addr,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  word_addr,
    output word_ready
  );

endinterface

// File: rtl/dither_packer_fifo2.sv
// Two-entry word FIFO with an older and a newer push port.
// Pushes beyond free space are dropped, newest first.
module packer_fifo2
  import dither_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_a,
  input  pack_word_t din_a,
  input  logic       push_b,
  input  pack_word_t din_b,
  input  logic       pop,
  output logic       valid,
  output pack_word_t head,
  output logic [1:0] free,
  output logic       drop
);

  pack_word_t mem [2];
  logic       rd;
  logic [1:0] cnt;
  logic       pop_ok;
  logic       take_a;
  logic       take_b;
  logic       wa;
  logic       wb;

  // Free space counts the slot vacated by a same-cycle pop
  always_comb begin
    pop_ok = pop && (cnt != 2'd0);
    free   = 2'd2 - cnt + {1'b0, pop_ok};
    take_a = push_a && (free != 2'd0);
    take_b = push_b &&
             (push_a ? (free == 2'd2)
                     : (free != 2'd0));
    drop   = (push_a && !take_a) ||
             (push_b && !take_b);
    wa     = rd ^ cnt[0];
    wb     = take_a ? ~wa : wa;
  end

  // Store accepted words behind the head, retire popped ones
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (take_a) mem[wa] <= din_a;
      if (take_b) mem[wb] <= din_b;
      if (pop_ok) rd <= ~rd;
      cnt <= cnt - {1'b0, pop_ok}
                 + {1'b0, take_a}
                 + {1'b0, take_b};
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = mem[rd];

endmodule

// File: rtl/dither_packer.sv
// Packs the 1-bit dithered stream LSB-first into 8-bit
// words tagged with their linear frame-buffer address.
module dither_packer
  import dither_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            dithered_valid,
  input  logic            dithered_pixel,
  input  logic [10:0]     dithered_hcount,
  input  logic [9:0]      dithered_vcount,
  dither_packer_if.master word_bus,
  output logic            frame_done,
  output logic            overflow,
  output logic            overflow_sticky
);

  localparam int WPR    = words_per_row(FRAME_W);
  localparam int ADDR_W = addr_bits(FRAME_W, FRAME_H);
  localparam int AW1    = ADDR_W + 1;

  localparam logic [10:0] H_END  = 11'(FRAME_W);
  localparam logic [10:0] H_LAST = 11'(FRAME_W - 1);
  localparam logic [9:0]  V_END  = 10'(FRAME_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(WPR * FRAME_H - 1);

  logic              p_ok;
  logic              p_pix;
  logic [10:0]       p_hc;
  logic [9:0]        p_vc;

  logic              acc_ne;
  logic [ADDR_W-1:0] acc_tag;
  logic [7:0]        acc_data;

  logic [AW1-1:0]    tag_w;
  logic [ADDR_W-1:0] tag;
  logic              mismatch;
  logic              complete;
  logic [7:0]        new_data;
  pack_word_t        old_word;
  pack_word_t        cur_word;

  logic              push_a;
  logic              push_b;
  pack_word_t        din_a;
  pack_word_t        din_b;
  logic              pop;
  logic              fifo_valid;
  pack_word_t        head;
  logic [1:0]        free_slots;
  logic              drop;
  logic [ADDR_W-1:0] head_addr;
  logic              unused_bits;

  // Capture in-range pixels; the accumulator works from flops
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      p_ok  <= 1'b0;
      p_pix <= 1'b0;
      p_hc  <= '0;
      p_vc  <= '0;
    end else begin
      p_ok  <= dithered_valid &&
               (dithered_hcount < H_END) &&
               (dithered_vcount < V_END);
      p_pix <= dithered_pixel;
      p_hc  <= dithered_hcount;
      p_vc  <= dithered_vcount;
    end
  end

  // Tag the pixel, detect jumps and word completion
  always_comb begin
    tag_w = AW1'(p_vc) * AW1'(WPR) + AW1'(p_hc[10:3]);
    tag   = tag_w[ADDR_W-1:0];
    mismatch = p_ok && acc_ne && (tag != acc_tag);
    complete = p_ok &&
               ((p_hc[2:0] == 3'd7) || (p_hc == H_LAST));
    new_data = (acc_ne && !mismatch) ? acc_data : 8'h00;
    new_data[p_hc[2:0]] = p_pix;
    old_word.addr = PACK_AW'(acc_tag);
    old_word.data = acc_data;
    cur_word.addr = PACK_AW'(tag);
    cur_word.data = new_data;
    push_a = mismatch || complete;
    din_a  = mismatch ? old_word : cur_word;
    push_b = mismatch && complete;
    din_b  = cur_word;
  end

  // Hold the partial word until it completes or is displaced
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_ne   <= 1'b0;
      acc_tag  <= '0;
      acc_data <= 8'h00;
    end else if (p_ok) begin
      if (complete) begin
        acc_ne   <= 1'b0;
        acc_data <= 8'h00;
      end else begin
        acc_ne   <= 1'b1;
        acc_tag  <= tag;
        acc_data <= new_data;
      end
    end
  end

  packer_fifo2 u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push_a (push_a),
    .din_a  (din_a),
    .push_b (push_b),
    .din_b  (din_b),
    .pop    (pop),
    .valid  (fifo_valid),
    .head   (head),
    .free   (free_slots),
    .drop   (drop)
  );

  assign head_addr = head.addr[ADDR_W-1:0];
  assign pop = fifo_valid && word_bus.word_ready;

  assign word_bus.word_valid = fifo_valid;
  assign word_bus.word_data  = head.data;
  assign word_bus.word_addr  = head_addr;

  // Registered status pulses for the accepted last word and drops
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_done      <= 1'b0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      frame_done      <= pop && (head_addr == LAST_ADDR);
      overflow        <= drop;
      overflow_sticky <= overflow_sticky | drop;
    end
  end

  assign unused_bits = ^{tag_w, head.addr, free_slots};

endmodule

// File: tb/tb_dither_packer.sv
// Bench for dither_packer on a 20x2 frame (3 words per row).
// Directed scenarios plus a randomized reference-model run.
module tb_dither_packer;
  import dither_pkg::*;

  localparam int FW   = 20;
  localparam int FH   = 2;
  localparam int WPR  = words_per_row(FW);
  localparam int AW   = addr_bits(FW, FH);
  localparam int LAST = WPR * FH - 1;
  localparam int MAXC = 512;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        dithered_valid = 1'b0;
  logic        dithered_pixel = 1'b0;
  logic [10:0] dithered_hcount = '0;
  logic [9:0]  dithered_vcount = '0;
  logic        frame_done;
  logic        overflow;
  logic        overflow_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int got_q[$];
  int fd_cnt  = 0;
  int ovf_cnt = 0;

  dither_packer_if #(.ADDR_W(AW)) bus ();

  dither_packer #(
    .FRAME_W(FW),
    .FRAME_H(FH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .dithered_valid  (dithered_valid),
    .dithered_pixel  (dithered_pixel),
    .dithered_hcount (dithered_hcount),
    .dithered_vcount (dithered_vcount),
    .word_bus        (bus),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (bus.word_valid && bus.word_ready)
        got_q.push_back(int'(bus.word_addr) * 256 +
                        int'(bus.word_data));
      if (frame_done) fd_cnt++;
      if (overflow) ovf_cnt++;
    end
  end

  task automatic put(input bit v, input bit p,
                     input int h, input int vc);
    @(posedge clk_in);
    #1;
    dithered_valid  = v;
    dithered_pixel  = p;
    dithered_hcount = 11'(h);
    dithered_vcount = 10'(vc);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    dithered_valid = 1'b0;
    bus.word_ready = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    bus.word_ready = 1'b1;
    #1;
    rst_in = 1'b0;
    #2;
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b want 0", bus.word_valid);
    end
    n_checks++;
    if (bus.word_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_data got %h want 00", bus.word_data);
    end
    n_checks++;
    if (bus.word_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_addr got %h want 0", bus.word_addr);
    end
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fd got %b want 0", frame_done);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ovf got %b want 0", overflow);
    end
    n_checks++;
    if (overflow_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sticky got %b want 0", overflow_sticky);
    end
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold_valid got %b want 0",
               bus.word_valid);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_pack_word();
    logic [7:0] pat;
    pat = 8'h8D;
    got_q.delete();
    for (int i = 0; i < 8; i++) put(1'b1, pat[i], i, 0);
    put(1'b0, 1'b0, 0, 0);
    @(negedge clk_in);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early got %b want 0", bus.word_valid);
    end
    put(1'b0, 1'b0, 0, 0);
    @(negedge clk_in);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h8D ||
        bus.word_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL lat_word got v=%b d=%h a=%0d want 1 8d 0",
               bus.word_valid, bus.word_data, bus.word_addr);
    end
    idle(4);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] != 32'h08D) begin
      n_fail++;
      $display("FAIL pack_word got n=%0d w=%h want 1 08d",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1);
    end
  endtask

  task automatic test_row_end();
    int fd0;
    got_q.delete();
    fd0 = fd_cnt;
    for (int h = 16; h < 20; h++) put(1'b1, 1'b1, h, 0);
    idle(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] != 2 * 256 + 8'h0F ||
        fd_cnt != fd0) begin
      n_fail++;
      $display("FAIL row0_end got n=%0d w=%h fd=%0d want 1 20f 0",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1,
               fd_cnt - fd0);
    end
    got_q.delete();
    for (int h = 16; h < 20; h++) put(1'b1, 1'b1, h, 1);
    idle(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] != 5 * 256 + 8'h0F) begin
      n_fail++;
      $display("FAIL row1_end got n=%0d w=%h want 1 50f",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1);
    end
    n_checks++;
    if (fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL frame_done got %0d pulses want 1",
               fd_cnt - fd0);
    end
  endtask

  task automatic test_jump();
    got_q.delete();
    for (int h = 0; h < 4; h++) put(1'b1, 1'b1, h, 0);
    put(1'b1, 1'b1, 9, 0);
    idle(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] != 8'h0F) begin
      n_fail++;
      $display("FAIL jump_flush got n=%0d w=%h want 1 00f",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1);
    end
    got_q.delete();
    put(1'b1, 1'b1, 19, 0);
    idle(5);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] != 256 + 8'h02 ||
        got_q[1] != 512 + 8'h08) begin
      n_fail++;
      $display("FAIL jump_double got n=%0d w0=%h w1=%h want 2 102 208",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1,
               (got_q.size() > 1) ? got_q[1] : -1);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] bits;
    int ov0;
    bits = 20'($urandom);
    got_q.delete();
    ov0 = ovf_cnt;
    bus.word_ready = 1'b0;
    for (int h = 0; h < 20; h++) put(1'b1, bits[h], h, 0);
    idle(5);
    n_checks++;
    if (ovf_cnt - ov0 != 1 || overflow_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pulse got %0d sticky=%b want 1 1",
               ovf_cnt - ov0, overflow_sticky);
    end
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_addr !== 3'd0 ||
        bus.word_data !== bits[7:0]) begin
      n_fail++;
      $display("FAIL ovf_head got v=%b a=%0d d=%h want 1 0 %h",
               bus.word_valid, bus.word_addr, bus.word_data,
               bits[7:0]);
    end
    idle(3);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_addr !== 3'd0 ||
        bus.word_data !== bits[7:0]) begin
      n_fail++;
      $display("FAIL ovf_stable got v=%b a=%0d d=%h want 1 0 %h",
               bus.word_valid, bus.word_addr, bus.word_data,
               bits[7:0]);
    end
    @(posedge clk_in);
    #1;
    bus.word_ready = 1'b1;
    idle(5);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] != int'(bits[7:0]) ||
        got_q[1] != 256 + int'(bits[15:8])) begin
      n_fail++;
      $display("FAIL ovf_drain got n=%0d w0=%h w1=%h want 2 %h %h",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1,
               (got_q.size() > 1) ? got_q[1] : -1,
               bits[7:0], 256 + int'(bits[15:8]));
    end
  endtask

  task automatic test_reset_midframe();
    got_q.delete();
    for (int h = 0; h < 4; h++) put(1'b1, 1'b1, h, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    dithered_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.word_valid !== 1'b0 || frame_done !== 1'b0 ||
        overflow !== 1'b0 || overflow_sticky !== 1'b0 ||
        bus.word_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b fd=%b o=%b s=%b d=%h want 0",
               bus.word_valid, frame_done, overflow,
               overflow_sticky, bus.word_data);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    for (int h = 4; h < 8; h++) put(1'b1, 1'b1, h, 0);
    idle(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] != 8'hF0) begin
      n_fail++;
      $display("FAIL mid_resume got n=%0d w=%h want 1 0f0",
               got_q.size(),
               (got_q.size() > 0) ? got_q[0] : -1);
    end
  endtask

  task automatic test_random(input int n, input int rdy_pct);
    bit v_a [MAXC];
    bit p_a [MAXC];
    int h_a [MAXC];
    int c_a [MAXC];
    bit r_a [MAXC];
    int nw  [MAXC];
    int w0  [MAXC];
    int w1  [MAXC];
    int q[$];
    int exp_q[$];
    int tot, h, vc, t, wd, e_ovf, e_fd, fd0, ov0, x;
    bit ne, dr;
    int tg, bits;
    tot = n + 12;
    h = 0;
    vc = 0;
    for (int i = 0; i < tot; i++) begin
      if (i < n) begin
        if ($urandom_range(3) != 0) begin
          h = h + 1;
          if (h > 21) begin
            h = 0;
            vc = (vc + 1) % 3;
          end
        end else begin
          h = $urandom_range(23);
          vc = $urandom_range(2);
        end
        v_a[i] = ($urandom_range(99) < 85);
        p_a[i] = 1'($urandom_range(1));
        r_a[i] = ($urandom_range(99) < rdy_pct);
      end else begin
        v_a[i] = 1'b0;
        p_a[i] = 1'b0;
        r_a[i] = 1'b1;
      end
      h_a[i] = h;
      c_a[i] = vc;
    end
    ne = 1'b0;
    tg = 0;
    bits = 0;
    for (int i = 0; i < tot; i++) begin
      nw[i] = 0;
      w0[i] = 0;
      w1[i] = 0;
      if (v_a[i] && h_a[i] < FW && c_a[i] < FH) begin
        t = c_a[i] * WPR + h_a[i] / 8;
        if (ne && t != tg) begin
          w0[i] = tg * 256 + bits;
          nw[i] = 1;
          ne = 1'b0;
        end
        if (!ne) begin
          tg = t;
          bits = 0;
          ne = 1'b1;
        end
        if (p_a[i]) bits = bits | (1 << (h_a[i] % 8));
        else bits = bits & ~(1 << (h_a[i] % 8));
        if (h_a[i] % 8 == 7 || h_a[i] == FW - 1) begin
          wd = tg * 256 + bits;
          if (nw[i] == 0) w0[i] = wd;
          else w1[i] = wd;
          nw[i]++;
          ne = 1'b0;
        end
      end
    end
    e_ovf = 0;
    e_fd = 0;
    for (int k = 1; k < tot; k++) begin
      if (q.size() > 0 && r_a[k-1]) begin
        x = q.pop_front();
        exp_q.push_back(x);
        if (x / 256 == LAST) e_fd++;
      end
      if (k >= 2) begin
        dr = 1'b0;
        for (int j = 0; j < nw[k-2]; j++) begin
          wd = (j == 0) ? w0[k-2] : w1[k-2];
          if (q.size() < 2) q.push_back(wd);
          else dr = 1'b1;
        end
        if (dr) e_ovf++;
      end
    end
    do_reset();
    idle(2);
    got_q.delete();
    fd0 = fd_cnt;
    ov0 = ovf_cnt;
    for (int i = 0; i < tot; i++) begin
      @(posedge clk_in);
      #1;
      dithered_valid  = v_a[i];
      dithered_pixel  = p_a[i];
      dithered_hcount = 11'(h_a[i]);
      dithered_vcount = 10'(c_a[i]);
      bus.word_ready  = r_a[i];
    end
    idle(4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd%0d_count got %0d want %0d",
               rdy_pct, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL rnd%0d_word[%0d] got %h want %h",
                 rdy_pct, i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (ovf_cnt - ov0 != e_ovf) begin
      n_fail++;
      $display("FAIL rnd%0d_ovf got %0d want %0d",
               rdy_pct, ovf_cnt - ov0, e_ovf);
    end
    n_checks++;
    if (fd_cnt - fd0 != e_fd) begin
      n_fail++;
      $display("FAIL rnd%0d_fd got %0d want %0d",
               rdy_pct, fd_cnt - fd0, e_fd);
    end
    n_checks++;
    if (overflow_sticky !== (e_ovf > 0)) begin
      n_fail++;
      $display("FAIL rnd%0d_sticky got %b want %b",
               rdy_pct, overflow_sticky, (e_ovf > 0));
    end
  endtask

  initial begin
    bus.word_ready = 1'b1;
    test_reset();
    test_pack_word();
    test_row_end();
    test_jump();
    test_overflow();
    test_reset_midframe();
    test_random(300, 100);
    test_random(300, 60);
    test_random(300, 25);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
